// File: rtl/i2c_slave_mem_ctrl.sv
// i2c_slave_mem_ctrl: byte-level I2C slave sequencer between the bit engine and the register memory.
// Decodes the device and register address bytes, then writes or reads the bytes of the selected register.
// Ports: start_det/stop_det/rx_valid/rx_byte/tx_req/master_nack come from the bit engine.
//        ack_valid/ack_bit and tx_valid/tx_byte go back to the bit engine.
//        mem_* is the memory request/response handshake; busy and err_timeout are status outputs.
module i2c_slave_mem_ctrl #(
  parameter logic [6:0] DEV_ADDR      = 7'h48,
  parameter int         ADDRESSLENGTH = 8,
  parameter int         ADDRESSNUM    = 2,
  parameter int         NBYTES        = 2,
  parameter int         MEM_TIMEOUT   = 16,
  parameter int         BIDX_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     start_det,
  input  logic                     stop_det,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     tx_req,
  input  logic                     master_nack,
  output logic                     ack_valid,
  output logic                     ack_bit,
  output logic                     tx_valid,
  output logic [7:0]               tx_byte,
  output logic                     mem_en,
  output logic                     mem_mode,
  output logic                     mem_rw,
  output logic [ADDRESSLENGTH-1:0] mem_addr,
  output logic [BIDX_W-1:0]        mem_bidx,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  input  logic                     mem_found,
  input  logic                     mem_ack,
  output logic                     busy,
  output logic                     err_timeout
);

  // Configurations this sequencer cannot support are rejected at elaboration.
  if (ADDRESSNUM < 1 || NBYTES < 1 || MEM_TIMEOUT < 2 ||
      ADDRESSLENGTH < 1 || ADDRESSLENGTH > 8) begin : g_bad_cfg
    $error("i2c_slave_mem_ctrl: unsupported parameter set");
  end

  localparam int TMO_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_REG,
    S_LOOKUP,
    S_WR_DATA,
    S_WR_MEM,
    S_RD_FETCH,
    S_RD_SEND,
    S_WAIT_STOP
  } state_t;

  state_t                   state_q, state_d;
  logic                     ack_valid_q, ack_valid_d;
  logic                     ack_bit_q, ack_bit_d;
  logic                     tx_valid_q, tx_valid_d;
  logic [7:0]               tx_byte_q, tx_byte_d;
  logic                     mem_en_q, mem_en_d;
  logic                     mem_mode_q, mem_mode_d;
  logic                     mem_rw_q, mem_rw_d;
  logic [ADDRESSLENGTH-1:0] mem_addr_q, mem_addr_d;
  logic [BIDX_W-1:0]        bidx_q, bidx_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     ptr_valid_q, ptr_valid_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     err_q, err_d;
  logic                     timed_out;

  function automatic logic [BIDX_W-1:0] next_idx(input logic [BIDX_W-1:0] i);
    if (i == BIDX_W'(NBYTES - 1)) return '0;
    return i + 1'b1;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ack_valid_q <= 1'b0;
      ack_bit_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_mode_q  <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      bidx_q      <= '0;
      wdata_q     <= '0;
      ptr_valid_q <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_valid_q <= ack_valid_d;
      ack_bit_q   <= ack_bit_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      mem_en_q    <= mem_en_d;
      mem_mode_q  <= mem_mode_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      bidx_q      <= bidx_d;
      wdata_q     <= wdata_d;
      ptr_valid_q <= ptr_valid_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
    end
  end

  // The counter only advances while a request is outstanding, so it is back
  // at zero before the next request can be issued.
  assign timed_out = mem_en_q && !mem_ack && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    ack_valid_d = 1'b0;
    ack_bit_d   = ack_bit_q;
    tx_valid_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    mem_en_d    = mem_en_q;
    mem_mode_d  = mem_mode_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    bidx_d      = bidx_q;
    wdata_d     = wdata_q;
    ptr_valid_d = ptr_valid_q;
    err_d       = err_q;
    tmo_d       = (mem_en_q && !mem_ack) ? tmo_q + 1'b1 : '0;

    // Bus conditions override everything; a mem_ack or rx byte in the same
    // cycle is dropped. Pointer and index survive a repeated START.
    if (start_det) begin
      state_d  = S_DEV;
      mem_en_d = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      mem_en_d = 1'b0;
    end else begin
      case (state_q)
        S_DEV: begin
          if (rx_valid) begin
            ack_valid_d = 1'b1;
            if (rx_byte[7:1] == DEV_ADDR) begin
              ack_bit_d = 1'b1;
              state_d   = rx_byte[0] ? S_RD_SEND : S_REG;
            end else begin
              ack_bit_d = 1'b0;
              state_d   = S_WAIT_STOP;
            end
          end
        end
        S_REG: begin
          // ACK for the register byte waits for the lookup result.
          if (rx_valid) begin
            mem_addr_d = rx_byte[ADDRESSLENGTH-1:0];
            mem_en_d   = 1'b1;
            mem_mode_d = 1'b1;
            mem_rw_d   = 1'b0;
            state_d    = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (mem_ack) begin
            mem_en_d    = 1'b0;
            ack_valid_d = 1'b1;
            ack_bit_d   = mem_found;
            ptr_valid_d = mem_found;
            if (mem_found) begin
              bidx_d  = '0;
              state_d = S_WR_DATA;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end else if (timed_out) begin
            mem_en_d    = 1'b0;
            err_d       = 1'b1;
            ack_valid_d = 1'b1;
            ack_bit_d   = 1'b0;
            state_d     = S_WAIT_STOP;
          end
        end
        S_WR_DATA: begin
          if (rx_valid) begin
            wdata_d    = rx_byte;
            mem_en_d   = 1'b1;
            mem_mode_d = 1'b0;
            mem_rw_d   = 1'b0;
            state_d    = S_WR_MEM;
          end
        end
        S_WR_MEM: begin
          if (mem_ack) begin
            mem_en_d    = 1'b0;
            ack_valid_d = 1'b1;
            ack_bit_d   = 1'b1;
            bidx_d      = next_idx(bidx_q);
            state_d     = S_WR_DATA;
          end else if (timed_out) begin
            mem_en_d    = 1'b0;
            err_d       = 1'b1;
            ack_valid_d = 1'b1;
            ack_bit_d   = 1'b0;
            state_d     = S_WAIT_STOP;
          end
        end
        S_RD_SEND: begin
          if (master_nack) begin
            state_d = S_WAIT_STOP;
          end else if (tx_req) begin
            if (ptr_valid_q) begin
              mem_en_d   = 1'b1;
              mem_mode_d = 1'b0;
              mem_rw_d   = 1'b1;
              state_d    = S_RD_FETCH;
            end else begin
              // No register selected: the bus sees an idle-high byte.
              tx_byte_d  = 8'hFF;
              tx_valid_d = 1'b1;
            end
          end
        end
        S_RD_FETCH: begin
          if (mem_ack) begin
            mem_en_d   = 1'b0;
            tx_byte_d  = mem_rdata;
            tx_valid_d = 1'b1;
            bidx_d     = next_idx(bidx_q);
            state_d    = S_RD_SEND;
          end else if (timed_out) begin
            mem_en_d   = 1'b0;
            err_d      = 1'b1;
            tx_byte_d  = 8'hFF;
            tx_valid_d = 1'b1;
            state_d    = S_WAIT_STOP;
          end
        end
        default: ;  // S_IDLE and S_WAIT_STOP only react to START/STOP.
      endcase
    end
  end

  assign ack_valid   = ack_valid_q;
  assign ack_bit     = ack_bit_q;
  assign tx_valid    = tx_valid_q;
  assign tx_byte     = tx_byte_q;
  assign mem_en      = mem_en_q;
  assign mem_mode    = mem_mode_q;
  assign mem_rw      = mem_rw_q;
  assign mem_addr    = mem_addr_q;
  assign mem_bidx    = bidx_q;
  assign mem_wdata   = wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_i2c_slave_mem_ctrl.sv
// tb_i2c_slave_mem_ctrl: drives byte-level I2C transactions into i2c_slave_mem_ctrl,
// emulates the register memory with random latency, and checks ACKs, transmit
// bytes and memory contents against a transaction-level model of the slave.
module tb_i2c_slave_mem_ctrl;
  localparam logic [6:0] DEV = 7'h48;
  localparam int         NB  = 2;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_det = 1'b0, stop_det = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_req = 1'b0, master_nack = 1'b0;
  logic       ack_valid, ack_bit, tx_valid;
  logic [7:0] tx_byte;
  logic       mem_en, mem_mode, mem_rw;
  logic [7:0] mem_addr;
  logic [0:0] mem_bidx;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_found = 1'b0, mem_ack = 1'b0;
  logic       busy, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory emulation (what the DUT actually wrote) and the model's view.
  logic [7:0] stor    [0:255][0:NB-1];
  logic [7:0] exp_mem [0:255][0:NB-1];
  bit         mem_hold = 1'b0;
  int         lat = 0;
  bit         en_seen = 1'b0;

  // Transaction-level model of the slave's persistent state.
  bit         m_ptr_v = 1'b0;
  logic [7:0] m_ptr = 8'h00;
  int         m_idx = 0;
  logic [7:0] wq [$];

  i2c_slave_mem_ctrl dut (
    .sys_clk(sys_clk), .rst(rst), .start_det(start_det), .stop_det(stop_det),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_req(tx_req), .master_nack(master_nack),
    .ack_valid(ack_valid), .ack_bit(ack_bit), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .mem_en(mem_en), .mem_mode(mem_mode), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_bidx(mem_bidx), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_found(mem_found), .mem_ack(mem_ack), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic bit is_reg(input logic [7:0] a);
    return (a == 8'h0E) || (a == 8'h0F);
  endfunction

  // Memory responder: acks each request after 1..4 cycles unless held off.
  always @(negedge sys_clk) begin
    if (mem_ack) begin
      mem_ack   = 1'b0;
      mem_found = 1'b0;
    end else if (mem_en && !mem_hold) begin
      if (lat == 0) lat = $urandom_range(1, 4);
      lat--;
      if (lat == 0) begin
        mem_ack = 1'b1;
        if (mem_mode)    mem_found = is_reg(mem_addr);
        else if (mem_rw) mem_rdata = stor[mem_addr][mem_bidx];
        else             stor[mem_addr][mem_bidx] = mem_wdata;
      end
    end else begin
      lat = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (mem_en) en_seen = 1'b1;
  endtask

  task automatic pulse_start();
    tick(); start_det = 1'b1; tick(); start_det = 1'b0;
  endtask

  task automatic pulse_stop();
    tick(); stop_det = 1'b1; tick(); stop_det = 1'b0;
  endtask

  task automatic pulse_mnack();
    tick(); master_nack = 1'b1; tick(); master_nack = 1'b0;
  endtask

  // Send a byte; expect an ACK/NACK pulse (exp_some) carrying exp_ack, or no pulse.
  task automatic send_rx(input logic [7:0] b, input bit exp_some, input bit exp_ack, input string tag);
    bit got = 1'b0;
    bit ab  = 1'b0;
    int budget = exp_some ? 40 : 8;
    tick(); rx_byte = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ack_valid) begin got = 1'b1; ab = ack_bit; break; end
      tick();
    end
    chk({tag, "_ackvld"}, 32'(got), 32'(exp_some));
    if (got && exp_some) chk({tag, "_ackbit"}, 32'(ab), 32'(exp_ack));
  endtask

  task automatic tx_read(input logic [7:0] exp_b, input string tag);
    bit got = 1'b0;
    logic [7:0] tb_v = 8'h00;
    tick(); tx_req = 1'b1; tick(); tx_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_valid) begin got = 1'b1; tb_v = tx_byte; break; end
      tick();
    end
    chk({tag, "_txvld"}, 32'(got), 32'd1);
    if (got) chk({tag, "_txbyte"}, 32'(tb_v), 32'(exp_b));
  endtask

  // Write transaction: device byte, register byte, then the bytes in wq.
  task automatic txn_write(input logic [7:0] dev, input logic [7:0] ra, input bit do_stop);
    logic [7:0] d;
    pulse_start();
    if (dev[7:1] != DEV) begin
      send_rx(dev, 1'b1, 1'b0, "wr_dev_miss");
      send_rx(ra, 1'b0, 1'b0, "wr_ign_reg");
      while (wq.size() > 0) begin d = wq.pop_front(); send_rx(d, 1'b0, 1'b0, "wr_ign_dat"); end
    end else begin
      send_rx(dev, 1'b1, 1'b1, "wr_dev");
      if (is_reg(ra)) begin
        send_rx(ra, 1'b1, 1'b1, "wr_reg_hit");
        m_ptr_v = 1'b1; m_ptr = ra; m_idx = 0;
        while (wq.size() > 0) begin
          d = wq.pop_front();
          send_rx(d, 1'b1, 1'b1, "wr_dat");
          exp_mem[m_ptr][m_idx] = d;
          m_idx = (m_idx + 1) % NB;
        end
      end else begin
        send_rx(ra, 1'b1, 1'b0, "wr_reg_miss");
        m_ptr_v = 1'b0;
        while (wq.size() > 0) begin d = wq.pop_front(); send_rx(d, 1'b0, 1'b0, "wr_dat_drop"); end
      end
    end
    if (do_stop) pulse_stop();
  endtask

  task automatic txn_read(input int n, input bit chk_wait);
    logic [7:0] e;
    pulse_start();
    send_rx({DEV, 1'b1}, 1'b1, 1'b1, "rd_dev");
    for (int i = 0; i < n; i++) begin
      if (m_ptr_v) begin
        e = exp_mem[m_ptr][m_idx];
        m_idx = (m_idx + 1) % NB;
      end else begin
        e = 8'hFF;
      end
      tx_read(e, "rd");
    end
    pulse_mnack();
    if (chk_wait) begin
      tick();
      chk("rd_wait_stop_busy", 32'(busy), 32'd1);
    end
    pulse_stop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int en_cyc;
    bit got;
    bit ab;

    for (int a = 0; a < 256; a++)
      for (int i = 0; i < NB; i++) begin
        b = 8'($urandom);
        stor[a][i] = b;
        exp_mem[a][i] = b;
      end
    stor[8'h0E][0] = 8'h11; exp_mem[8'h0E][0] = 8'h11;
    stor[8'h0E][1] = 8'h22; exp_mem[8'h0E][1] = 8'h22;

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_out_a", {ack_valid, ack_bit, tx_valid, tx_byte, mem_en, mem_mode, mem_rw, mem_addr}, 32'd0);
    chk("rst_out_b", {mem_bidx, mem_wdata, busy, err_timeout}, 32'd0);

    // 1. Two-byte write to 0x0F.
    wq = '{8'hAA, 8'hBB};
    txn_write({DEV, 1'b0}, 8'h0F, 1'b1);
    tick();
    chk("t1_mem_idx0", 32'(stor[8'h0F][0]), 32'hAA);
    chk("t1_mem_idx1", 32'(stor[8'h0F][1]), 32'hBB);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2. Register lookup miss.
    wq = '{8'h33, 8'h44};
    txn_write({DEV, 1'b0}, 8'h05, 1'b1);

    // 3. Set pointer to 0x0E, repeated START, read three bytes (index wraps).
    wq.delete();
    txn_write({DEV, 1'b0}, 8'h0E, 1'b0);
    txn_read(3, 1'b1);

    // 4. Device address miss: no memory activity at all.
    en_seen = 1'b0;
    wq = '{8'h01};
    txn_write(8'h92, 8'h0F, 1'b1);
    chk("t4_no_mem_en", 32'(en_seen), 32'd0);

    // 5. Memory never answers a data write.
    pulse_start();
    send_rx({DEV, 1'b0}, 1'b1, 1'b1, "t5_dev");
    send_rx(8'h0F, 1'b1, 1'b1, "t5_reg");
    m_ptr_v = 1'b1; m_ptr = 8'h0F; m_idx = 0;
    mem_hold = 1'b1;
    tick(); rx_byte = 8'h5A; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    en_cyc = 0; got = 1'b0; ab = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (mem_en) en_cyc++;
      if (ack_valid) begin got = 1'b1; ab = ack_bit; break; end
      tick();
    end
    mem_hold = 1'b0;
    chk("t5_en_cycles", 32'(en_cyc), 32'd16);
    chk("t5_ackvld", 32'(got), 32'd1);
    chk("t5_nack", 32'(ab), 32'd0);
    chk("t5_err", 32'(err_timeout), 32'd1);
    pulse_stop();
    tick();
    chk("t5_err_after_stop", 32'(err_timeout), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);

    // 6. Reset while a read fetch is outstanding.
    pulse_start();
    send_rx({DEV, 1'b1}, 1'b1, 1'b1, "t6_dev");
    mem_hold = 1'b1;
    tick(); tx_req = 1'b1; tick(); tx_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_en) break;
      tick();
    end
    chk("t6_fetch_en", 32'(mem_en), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    mem_hold = 1'b0;
    chk("t6_rst_out_a", {ack_valid, ack_bit, tx_valid, tx_byte, mem_en, mem_mode, mem_rw, mem_addr}, 32'd0);
    chk("t6_rst_out_b", {mem_bidx, mem_wdata, busy, err_timeout}, 32'd0);
    m_ptr_v = 1'b0; m_idx = 0;
    txn_read(1, 1'b0);

    // Randomized mix of writes, reads and foreign-address transactions.
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 3);
      int sel;
      logic [7:0] ra;
      logic [7:0] dv;
      wq.delete();
      if (kind <= 1) begin
        sel = $urandom_range(0, 3);
        ra = (sel == 0) ? 8'h0E : (sel == 1) ? 8'h0F : 8'($urandom);
        for (int k = 0, n = $urandom_range(0, 3); k < n; k++) wq.push_back(8'($urandom));
        txn_write({DEV, 1'b0}, ra, ($urandom_range(0, 1) == 1));
        if (stop_det == 1'b0 && busy) begin
          txn_read($urandom_range(1, 3), 1'b0);
        end
      end else if (kind == 2) begin
        txn_read($urandom_range(1, 4), 1'b0);
      end else begin
        dv = 8'($urandom);
        if (dv[7:1] == DEV) dv = dv ^ 8'h80;
        wq.push_back(8'($urandom));
        txn_write(dv, 8'h0F, 1'b1);
      end
    end

    tick();
    for (int a = 14; a < 16; a++)
      for (int i = 0; i < NB; i++)
        chk($sformatf("final_mem_%0h_%0d", a, i), 32'(stor[a][i]), 32'(exp_mem[a][i]));
    chk("final_err", 32'(err_timeout), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
